// File: rtl/ysyx_2022040010_mem_pipe_if.sv
// EXU -> MEM -> WBU bus bundle, including the data-SRAM read response and the ID forwarding bus.
// ld_misalign exists only when YSYX_2022040010_MEM_MISALIGN_EN is defined.
interface ysyx_2022040010_mem_pipe_if #(
  parameter int XLEN  = 64,
  parameter int PC_W  = 64,
  parameter int RF_AW = 5
);
  logic             ex_valid;
  logic             ex_ready;
  logic [PC_W-1:0]  ex_pc;
  logic             ex_is_load;
  logic [1:0]       ex_ld_size;
  logic             ex_ld_unsigned;
  logic             ex_rf_we;
  logic [RF_AW-1:0] ex_rf_waddr;
  logic [XLEN-1:0]  ex_result;

  logic             dsram_rvalid;
  logic [XLEN-1:0]  dsram_rdata;

  logic             wb_valid;
  logic             wb_ready;
  logic [PC_W-1:0]  wb_pc;
  logic             wb_rf_we;
  logic [RF_AW-1:0] wb_rf_waddr;
  logic [XLEN-1:0]  wb_rf_wdata;

  logic             fwd_we;
  logic [RF_AW-1:0] fwd_waddr;
  logic [XLEN-1:0]  fwd_wdata;
  logic             fwd_pending;
`ifdef YSYX_2022040010_MEM_MISALIGN_EN
  logic             ld_misalign;
`endif

  modport slave (
    input  ex_valid, ex_pc, ex_is_load, ex_ld_size, ex_ld_unsigned,
    input  ex_rf_we, ex_rf_waddr, ex_result,
    input  dsram_rvalid, dsram_rdata, wb_ready,
`ifdef YSYX_2022040010_MEM_MISALIGN_EN
    output ld_misalign,
`endif
    output ex_ready, wb_valid, wb_pc, wb_rf_we, wb_rf_waddr, wb_rf_wdata,
    output fwd_we, fwd_waddr, fwd_wdata, fwd_pending
  );

  modport master (
    output ex_valid, ex_pc, ex_is_load, ex_ld_size, ex_ld_unsigned,
    output ex_rf_we, ex_rf_waddr, ex_result,
    output dsram_rvalid, dsram_rdata, wb_ready,
`ifdef YSYX_2022040010_MEM_MISALIGN_EN
    input  ld_misalign,
`endif
    input  ex_ready, wb_valid, wb_pc, wb_rf_we, wb_rf_waddr, wb_rf_wdata,
    input  fwd_we, fwd_waddr, fwd_wdata, fwd_pending
  );
endinterface

// File: rtl/ysyx_2022040010_mem_pipe.sv
// MEM stage as a one-entry elastic slot (IDLE/WAIT/FULL) with variable-latency load return and ID forwarding.
// Optional YSYX_2022040010_MEM_MISALIGN_EN flags misaligned loads and suppresses their register write.
module ysyx_2022040010_mem_pipe #(
  parameter int XLEN  = 64,
  parameter int PC_W  = 64,
  parameter int RF_AW = 5
) (
  input logic clk,
  input logic rst,
  ysyx_2022040010_mem_pipe_if.slave bus
);
  localparam int OFF_W = $clog2(XLEN / 8);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    FULL = 2'd2
  } state_t;

  state_t           state_p1, state_nxt;
  logic             ex_rdy, accept, rsp_take;
  logic [PC_W-1:0]  pc_p1;
  logic             rf_we_p1;
  logic [RF_AW-1:0] waddr_p1;
  logic [XLEN-1:0]  wdata_p1;
  logic [1:0]       size_p1;
  logic             uns_p1;
  logic             vld_p1;
  logic             live_wr;
`ifdef YSYX_2022040010_MEM_MISALIGN_EN
  logic             misal_p1;
`endif

  // A doubleword access on a 32-bit datapath degrades to a word access.
  function automatic logic [1:0] eff_size(input logic [1:0] size);
    return (XLEN == 32 && size == 2'd3) ? 2'd2 : size;
  endfunction

  function automatic logic [XLEN-1:0] ld_extract(input logic [XLEN-1:0] word,
                                                 input logic [OFF_W-1:0] off,
                                                 input logic [1:0] size,
                                                 input logic uns);
    logic [XLEN-1:0] sh, mask, ext;
    logic            sgn;
    sh = word >> {off, 3'b000};
    case (eff_size(size))
      2'd0: begin mask = ~({XLEN{1'b1}} << 8);  sgn = sh[7];      end
      2'd1: begin mask = ~({XLEN{1'b1}} << 16); sgn = sh[15];     end
      2'd2: begin mask = ~({XLEN{1'b1}} << 32); sgn = sh[31];     end
      default: begin mask = {XLEN{1'b1}};       sgn = sh[XLEN-1]; end
    endcase
    ext = (sgn && !uns) ? ~mask : '0;
    return (sh & mask) | ext;
  endfunction

`ifdef YSYX_2022040010_MEM_MISALIGN_EN
  function automatic logic ld_misaligned(input logic [OFF_W-1:0] off, input logic [1:0] size);
    logic [OFF_W-1:0] amask;
    amask = OFF_W'((1 << eff_size(size)) - 1);
    return |(off & amask);
  endfunction
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_p1 <= IDLE;
    else      state_p1 <= state_nxt;
  end

  // Response is only looked at in WAIT, so one arriving with or before the accept is dropped.
  always_comb begin
    state_nxt = state_p1;
    ex_rdy    = 1'b0;
    rsp_take  = 1'b0;
    case (state_p1)
      IDLE: ex_rdy = rst;
      WAIT: begin
        if (bus.dsram_rvalid) begin
          rsp_take  = 1'b1;
          state_nxt = FULL;
        end
      end
      FULL: begin
        ex_rdy = rst & bus.wb_ready;
        if (bus.wb_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    accept = bus.ex_valid & ex_rdy;
    if (accept) state_nxt = bus.ex_is_load ? WAIT : FULL;
  end

  // ---- stage p1: slot capture; for loads wdata_p1 holds the byte address until the response ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_p1    <= '0;
      rf_we_p1 <= 1'b0;
      waddr_p1 <= '0;
      wdata_p1 <= '0;
      size_p1  <= 2'd0;
      uns_p1   <= 1'b0;
`ifdef YSYX_2022040010_MEM_MISALIGN_EN
      misal_p1 <= 1'b0;
`endif
    end else if (accept) begin
      pc_p1    <= bus.ex_pc;
      rf_we_p1 <= bus.ex_rf_we;
      waddr_p1 <= bus.ex_rf_waddr;
      wdata_p1 <= bus.ex_result;
      size_p1  <= bus.ex_ld_size;
      uns_p1   <= bus.ex_ld_unsigned;
`ifdef YSYX_2022040010_MEM_MISALIGN_EN
      misal_p1 <= bus.ex_is_load & ld_misaligned(bus.ex_result[OFF_W-1:0], bus.ex_ld_size);
`endif
    end else if (rsp_take) begin
      wdata_p1 <= ld_extract(bus.dsram_rdata, wdata_p1[OFF_W-1:0], size_p1, uns_p1);
    end
  end

  assign vld_p1  = (state_p1 == FULL);
  assign live_wr = (state_p1 != IDLE) & rf_we_p1 & (waddr_p1 != '0);

  assign bus.ex_ready    = ex_rdy;
  assign bus.wb_valid    = vld_p1;
  assign bus.wb_pc       = pc_p1;
  assign bus.wb_rf_waddr = waddr_p1;
  assign bus.wb_rf_wdata = wdata_p1;
`ifdef YSYX_2022040010_MEM_MISALIGN_EN
  assign bus.wb_rf_we    = rf_we_p1 & (waddr_p1 != '0) & ~misal_p1;
  assign bus.ld_misalign = misal_p1;
`else
  assign bus.wb_rf_we    = rf_we_p1 & (waddr_p1 != '0);
`endif

  assign bus.fwd_we      = live_wr;
  assign bus.fwd_waddr   = waddr_p1;
  assign bus.fwd_wdata   = wdata_p1;
  assign bus.fwd_pending = (state_p1 == WAIT) & live_wr;
endmodule

// File: tb/tb_ysyx_2022040010_mem_pipe.sv
// Directed bench for the MEM slot: reset, back-to-back ALU ops, load extraction, backpressure, x0 and stale responses.
module tb_ysyx_2022040010_mem_pipe;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  ysyx_2022040010_mem_pipe_if #(.XLEN(64), .PC_W(64), .RF_AW(5)) bus ();

  ysyx_2022040010_mem_pipe #(.XLEN(64), .PC_W(64), .RF_AW(5)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [63:0] addr;
    logic [1:0]  size;
    logic        uns;
    logic [63:0] rdata;
    int          dly;
    logic [63:0] exp;
  } ld_vec_t;

  ld_vec_t lv[8];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_op(input logic [63:0] pc, input logic [4:0] waddr, input logic [63:0] res);
    bus.ex_valid       = 1'b1;
    bus.ex_is_load     = 1'b0;
    bus.ex_ld_size     = 2'd0;
    bus.ex_ld_unsigned = 1'b0;
    bus.ex_rf_we       = 1'b1;
    bus.ex_pc          = pc;
    bus.ex_rf_waddr    = waddr;
    bus.ex_result      = res;
  endtask

  // Issue a load, check the WAIT view, return the response dly cycles after accept; ends with the slot FULL.
  task automatic run_load(input string tag, input logic [63:0] addr, input logic [1:0] size,
                          input logic uns, input logic [4:0] waddr, input logic rfwe,
                          input logic [63:0] rdata, input int dly);
    logic exp_fwd;
    exp_fwd            = rfwe && (waddr != 5'd0);
    bus.ex_valid       = 1'b1;
    bus.ex_is_load     = 1'b1;
    bus.ex_ld_size     = size;
    bus.ex_ld_unsigned = uns;
    bus.ex_rf_we       = rfwe;
    bus.ex_rf_waddr    = waddr;
    bus.ex_result      = addr;
    bus.ex_pc          = addr + 64'h1000;
    tick();
    bus.ex_valid   = 1'b0;
    bus.ex_is_load = 1'b0;
    #1;
    chk({tag, "_wait_rdy"}, 64'(bus.ex_ready), 64'd0);
    chk({tag, "_wait_pend"}, 64'(bus.fwd_pending), 64'(exp_fwd));
    chk({tag, "_wait_fwe"}, 64'(bus.fwd_we), 64'(exp_fwd));
    for (int i = 1; i < dly; i++) tick();
    bus.dsram_rvalid = 1'b1;
    bus.dsram_rdata  = rdata;
    tick();
    bus.dsram_rvalid = 1'b0;
    bus.dsram_rdata  = 64'd0;
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst   = 1'b0;
    bus.ex_valid = 1'b0;   bus.ex_pc = 64'd0;        bus.ex_is_load = 1'b0;
    bus.ex_ld_size = 2'd0; bus.ex_ld_unsigned = 1'b0; bus.ex_rf_we = 1'b0;
    bus.ex_rf_waddr = 5'd0; bus.ex_result = 64'd0;   bus.dsram_rvalid = 1'b0;
    bus.dsram_rdata = 64'd0; bus.wb_ready = 1'b0;

    lv[0] = '{"lb",   64'h8000_0003, 2'd0, 1'b0, 64'h0000_0000_80FF_7F00, 3, 64'hFFFF_FFFF_FFFF_FF80};
    lv[1] = '{"lbu",  64'h8000_0003, 2'd0, 1'b1, 64'h0000_0000_80FF_7F00, 3, 64'h0000_0000_0000_0080};
    lv[2] = '{"lh",   64'h8000_0006, 2'd1, 1'b0, 64'h8001_0000_0000_0000, 1, 64'hFFFF_FFFF_FFFF_8001};
    lv[3] = '{"lw",   64'h8000_0004, 2'd2, 1'b0, 64'h7FFF_FFFF_0000_0000, 2, 64'h0000_0000_7FFF_FFFF};
    lv[4] = '{"ld",   64'h8000_0008, 2'd3, 1'b0, 64'h8123_4567_89AB_CDEF, 1, 64'h8123_4567_89AB_CDEF};
    lv[5] = '{"lhu",  64'h8000_0002, 2'd1, 1'b1, 64'h0000_0000_ABCD_0000, 1, 64'h0000_0000_0000_ABCD};
    lv[6] = '{"lw_s", 64'h8000_0000, 2'd2, 1'b0, 64'h0000_0000_8000_0000, 4, 64'hFFFF_FFFF_8000_0000};
    lv[7] = '{"lb_p", 64'h8000_0001, 2'd0, 1'b0, 64'h0000_0000_80FF_7F00, 1, 64'h0000_0000_0000_007F};

    // Reset, then reset again while the slot holds a result.
    tick(); tick();
    chk("rst_rdy", 64'(bus.ex_ready), 64'd0);
    chk("rst_wbv", 64'(bus.wb_valid), 64'd0);
    rst = 1'b1;
    #1;
    chk("rel_rdy", 64'(bus.ex_ready), 64'd1);
    send_op(64'h100, 5'd3, 64'h99);
    tick();
    bus.ex_valid = 1'b0;
    #1;
    chk("pre_wbv", 64'(bus.wb_valid), 64'd1);
    chk("pre_wd", bus.wb_rf_wdata, 64'h99);
    rst = 1'b0;
    #1;
    chk("mid_wbv", 64'(bus.wb_valid), 64'd0);
    chk("mid_rdy", 64'(bus.ex_ready), 64'd0);
    chk("mid_wd", bus.wb_rf_wdata, 64'd0);
    tick();
    rst = 1'b1;
    #1;
    chk("post_rdy", 64'(bus.ex_ready), 64'd1);
    chk("post_wbv", 64'(bus.wb_valid), 64'd0);
    chk("post_pc", bus.wb_pc, 64'd0);
    chk("post_wd", bus.wb_rf_wdata, 64'd0);
    chk("post_we", 64'(bus.wb_rf_we), 64'd0);

    // Back-to-back ALU results at full rate.
    bus.wb_ready = 1'b1;
    send_op(64'h200, 5'd1, 64'h11);
    #1;
    chk("b2b_rdy0", 64'(bus.ex_ready), 64'd1);
    tick();
    send_op(64'h204, 5'd1, 64'h22);
    #1;
    chk("b2b_wd1", bus.wb_rf_wdata, 64'h11);
    chk("b2b_wbv1", 64'(bus.wb_valid), 64'd1);
    chk("b2b_rdy1", 64'(bus.ex_ready), 64'd1);
    tick();
    send_op(64'h208, 5'd1, 64'h33);
    #1;
    chk("b2b_wd2", bus.wb_rf_wdata, 64'h22);
    chk("b2b_rdy2", 64'(bus.ex_ready), 64'd1);
    tick();
    bus.ex_valid = 1'b0;
    #1;
    chk("b2b_wd3", bus.wb_rf_wdata, 64'h33);
    chk("b2b_pc3", bus.wb_pc, 64'h208);
    chk("b2b_wbv3", 64'(bus.wb_valid), 64'd1);
    tick();
    chk("b2b_idle", 64'(bus.wb_valid), 64'd0);

    // Load extraction table.
    for (int k = 0; k < 8; k++) begin
      run_load(lv[k].tag, lv[k].addr, lv[k].size, lv[k].uns, 5'd7, 1'b1, lv[k].rdata, lv[k].dly);
      chk({lv[k].tag, "_wd"}, bus.wb_rf_wdata, lv[k].exp);
      chk({lv[k].tag, "_we"}, 64'(bus.wb_rf_we), 64'd1);
      chk({lv[k].tag, "_wbv"}, 64'(bus.wb_valid), 64'd1);
      chk({lv[k].tag, "_pend"}, 64'(bus.fwd_pending), 64'd0);
`ifdef YSYX_2022040010_MEM_MISALIGN_EN
      chk({lv[k].tag, "_mis"}, 64'(bus.ld_misalign), 64'd0);
`endif
      tick();
    end

    // Misaligned word at offset 6: bytes past the word read as zero.
    run_load("lw_mis", 64'h8000_0006, 2'd2, 1'b0, 5'd7, 1'b1, 64'h1234_5678_9ABC_DEF0, 1);
    chk("lw_mis_wd", bus.wb_rf_wdata, 64'h0000_0000_0000_1234);
`ifdef YSYX_2022040010_MEM_MISALIGN_EN
    chk("lw_mis_we", 64'(bus.wb_rf_we), 64'd0);
    chk("lw_mis_flag", 64'(bus.ld_misalign), 64'd1);
`else
    chk("lw_mis_we", 64'(bus.wb_rf_we), 64'd1);
`endif
    tick();

    // WB backpressure with a younger instruction waiting.
    bus.wb_ready = 1'b0;
    send_op(64'h300, 5'd5, 64'hAB);
    tick();
    send_op(64'h304, 5'd6, 64'hCD);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("bp_wbv", 64'(bus.wb_valid), 64'd1);
      chk("bp_wd", bus.wb_rf_wdata, 64'hAB);
      chk("bp_wa", 64'(bus.wb_rf_waddr), 64'd5);
      chk("bp_pc", bus.wb_pc, 64'h300);
      chk("bp_rdy", 64'(bus.ex_ready), 64'd0);
      chk("bp_fwe", 64'(bus.fwd_we), 64'd1);
      chk("bp_fpend", 64'(bus.fwd_pending), 64'd0);
      chk("bp_fwd", bus.fwd_wdata, 64'hAB);
      tick();
    end
    bus.wb_ready = 1'b1;
    #1;
    chk("bp_rel_rdy", 64'(bus.ex_ready), 64'd1);
    tick();
    bus.ex_valid = 1'b0;
    #1;
    chk("bp_next_wd", bus.wb_rf_wdata, 64'hCD);
    chk("bp_next_wa", 64'(bus.wb_rf_waddr), 64'd6);
    chk("bp_next_wbv", 64'(bus.wb_valid), 64'd1);
    tick();
    chk("bp_idle", 64'(bus.wb_valid), 64'd0);

    // Load to x0, and a load that does not write the register file.
    run_load("x0", 64'h10, 2'd3, 1'b0, 5'd0, 1'b1, 64'h55, 2);
    chk("x0_we", 64'(bus.wb_rf_we), 64'd0);
    chk("x0_wd", bus.wb_rf_wdata, 64'h55);
    chk("x0_wbv", 64'(bus.wb_valid), 64'd1);
    tick();
    run_load("nowe", 64'h18, 2'd3, 1'b0, 5'd9, 1'b0, 64'h66, 1);
    chk("nowe_we", 64'(bus.wb_rf_we), 64'd0);
    chk("nowe_wd", bus.wb_rf_wdata, 64'h66);
    tick();

    // Stray response while IDLE.
    bus.dsram_rvalid = 1'b1;
    bus.dsram_rdata  = 64'hFFFF;
    tick(); tick();
    chk("spur_wbv", 64'(bus.wb_valid), 64'd0);
    chk("spur_rdy", 64'(bus.ex_ready), 64'd1);
    chk("spur_fwe", 64'(bus.fwd_we), 64'd0);

    // Response coincident with the accept edge must not complete the load.
    bus.ex_valid = 1'b1;  bus.ex_is_load = 1'b1; bus.ex_ld_size = 2'd3;
    bus.ex_rf_we = 1'b1;  bus.ex_rf_waddr = 5'd8; bus.ex_result = 64'h20;
    bus.dsram_rdata = 64'hDEAD;
    tick();
    bus.ex_valid = 1'b0;  bus.ex_is_load = 1'b0; bus.dsram_rvalid = 1'b0;
    #1;
    chk("coin_rdy", 64'(bus.ex_ready), 64'd0);
    chk("coin_wbv", 64'(bus.wb_valid), 64'd0);
    bus.dsram_rvalid = 1'b1;
    bus.dsram_rdata  = 64'h77;
    tick();
    bus.dsram_rvalid = 1'b0;
    #1;
    chk("coin_wd", bus.wb_rf_wdata, 64'h77);
    tick();

    // Reset during WAIT, then a stale response.
    bus.ex_valid = 1'b1;  bus.ex_is_load = 1'b1; bus.ex_ld_size = 2'd3;
    bus.ex_rf_we = 1'b1;  bus.ex_rf_waddr = 5'd4; bus.ex_result = 64'h28;
    tick();
    bus.ex_valid = 1'b0;  bus.ex_is_load = 1'b0;
    #1;
    chk("rw_pend", 64'(bus.fwd_pending), 64'd1);
    rst = 1'b0;
    #1;
    chk("rw_rst_pend", 64'(bus.fwd_pending), 64'd0);
    chk("rw_rst_rdy", 64'(bus.ex_ready), 64'd0);
    tick();
    rst = 1'b1;
    bus.dsram_rvalid = 1'b1;
    bus.dsram_rdata  = 64'h99;
    tick();
    bus.dsram_rvalid = 1'b0;
    #1;
    chk("rw_stale_wbv", 64'(bus.wb_valid), 64'd0);
    chk("rw_stale_rdy", 64'(bus.ex_ready), 64'd1);
    chk("rw_stale_fwe", 64'(bus.fwd_we), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ysyx_2022040010_mem_pipe.md
Name: ysyx_2022040010_mem_pipe

Overview:
Parametrised successor MEM stage between EXU and WBU, implemented as a one-entry elastic pipeline slot. It has valid/ready handshakes on both sides and supports variable-latency data-SRAM read responses. Load data is extracted by address offset (any byte lane), then sized and sign- or zero-extended. A forwarding/hazard bus goes to ID, including a "load pending" flag so ID can stall.

Parameters:
XLEN, 64, datapath width (32 or 64)
PC_W, 64, PC width
RF_AW, 5, register-file address width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset; low = reset
ex_valid  in  1  EXU offers instruction
ex_ready  out  1  slot can accept
ex_pc  in  PC_W  instruction PC
ex_is_load  in  1  instruction is a load
ex_ld_size  in  2  0=B,1=H,2=W,3=D
ex_ld_unsigned  in  1  zero-extend load
ex_rf_we  in  1  writes register file
ex_rf_waddr  in  RF_AW  destination register
ex_result  in  XLEN  ALU result; for loads, the byte address
dsram_rvalid  in  1  read response valid
dsram_rdata  in  XLEN  aligned read word
wb_valid  out  1  result offered to WBU
wb_ready  in  1  WBU accepts
wb_pc  out  PC_W  PC
wb_rf_we  out  1  write enable
wb_rf_waddr  out  RF_AW  destination
wb_rf_wdata  out  XLEN  write data
fwd_we  out  1  slot holds live write to nonzero rd
fwd_waddr  out  RF_AW  forwarded rd
fwd_wdata  out  XLEN  forwarded data
fwd_pending  out  1  rd data not yet available (load waiting)

Behaviour:
- Reset (rst low, async): state=IDLE; all registered outputs 0; ex_ready=0 while rst low; wb_valid=0.
- States:
  - IDLE: empty.
  - WAIT: load accepted, data pending.
  - FULL: result held.
- ex_ready = IDLE | (FULL & wb_ready). ex_ready is 0 in WAIT.
- Accept = ex_valid & ex_ready.
  - On accept, capture all ex_* fields.
  - Next state is WAIT if ex_is_load, else FULL.
  - For a non-load, wdata = ex_result.
- WAIT: on dsram_rvalid, wdata = extract(dsram_rdata) and go to FULL. Response counts only from the cycle after accept. dsram_rvalid in IDLE or FULL is ignored.
- FULL:
  - wb_valid=1.
  - wb_ready & !ex_valid -> IDLE.
  - wb_ready & ex_valid -> accept back-to-back, giving full throughput of 1 instruction/cycle for non-loads.
- FULL & !wb_ready: all wb_* outputs stable until handshake.
- Extract:
  - off = ex_result[log2(XLEN/8)-1:0].
  - sh = dsram_rdata >> (8*off).
  - Keep the low 8/16/32/64 bits per size.
  - Sign-extend from the top kept bit unless ld_unsigned.
  - size 3 with XLEN=32 is treated as size 2.
- Loads with ex_rf_we=0 still wait for the response, then retire with wb_rf_we=0.
- wb_rf_we is forced 0 when rf_waddr==0. wb_rf_wdata is still driven.
- fwd_we = (state!=IDLE) & rf_we & (waddr!=0).
- fwd_pending = (state==WAIT) & fwd_we.
- fwd_wdata is valid only when fwd_pending=0.
- Reset mid-WAIT: state returns to IDLE. Any later stale dsram_rvalid is ignored because the slot is IDLE.

Optional Feature:
YSYX_2022040010_MEM_MISALIGN_EN:
- Defined:
  - Adds output ld_misalign (1 bit), registered with the slot.
  - Set when the load offset is not a multiple of the access size.
  - The instruction still waits for dsram_rvalid.
  - On retirement, wb_rf_we=0 and ld_misalign=1 while wb_valid.
- Undefined: misaligned loads are extracted normally from the word (bytes beyond the word read as 0), and the port is absent.

Test Plan:
1. Reset with rst=0 mid-stream -> wb_valid=0, ex_ready=0. After release ex_ready=1, wb_* outputs=0.
2. Back-to-back non-loads, wb_ready=1: ex_result=0x11, 0x22, 0x33 on consecutive cycles -> wb_valid each cycle with wdata 0x11, 0x22, 0x33, ex_ready held 1.
3. lb, off=3, rdata=0x00000000_80FF7F00, rvalid 3 cycles after accept -> ex_ready=0 during WAIT, fwd_pending=1, then wdata=0xFFFFFFFF_FFFFFF80. Same case as lbu -> 0x80.
4. lh, off=6, rdata=0x8001_0000_0000_0000, signed -> 0xFFFF_FFFF_FFFF_8001; lw, off=4, rdata=0x7FFF_FFFF_0000_0000 -> 0x7FFF_FFFF.
5. WB backpressure: wb_ready=0 for 4 cycles while FULL with waddr=5, data=0xAB -> outputs stable, ex_ready=0, fwd_we=1, fwd_pending=0. After wb_ready=1, a pending ex_valid is accepted the same cycle.
6. Load to x0 (waddr=0) -> fwd_we=0, wb_rf_we=0. Spurious dsram_rvalid while IDLE -> no state change.
